// File: rtl/computer_datapath_regfile_sequencer.sv
// Round-robin sequencer sharing a dual-read/single-write regfile between two requesters.
// Optional post-reset clear of every register is built when RF_INIT_CLEAR_EN is defined.
module computer_datapath_regfile_sequencer #(
  parameter int WORD_WIDTH  = 16,
  parameter int DR_WIDTH    = 3,
  parameter int CNTRL_WIDTH = 20
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_req0_valid,
  output logic                   o_req0_ready,
  input  logic [DR_WIDTH-1:0]    i_req0_da,
  input  logic [DR_WIDTH-1:0]    i_req0_aa,
  input  logic [DR_WIDTH-1:0]    i_req0_ba,
  input  logic                   i_req0_rw,
  input  logic [WORD_WIDTH-1:0]  i_req0_data,
  input  logic                   i_req1_valid,
  output logic                   o_req1_ready,
  input  logic [DR_WIDTH-1:0]    i_req1_da,
  input  logic [DR_WIDTH-1:0]    i_req1_aa,
  input  logic [DR_WIDTH-1:0]    i_req1_ba,
  input  logic                   i_req1_rw,
  input  logic [WORD_WIDTH-1:0]  i_req1_data,
  input  logic [WORD_WIDTH-1:0]  i_addr_bus,
  input  logic [WORD_WIDTH-1:0]  i_b_data,
  output logic [CNTRL_WIDTH-1:0] o_cntrl_bus,
  output logic [WORD_WIDTH-1:0]  o_d_bus,
  output logic                   o_rsp_valid,
  output logic                   o_rsp_id,
  output logic [WORD_WIDTH-1:0]  o_rsp_a,
  output logic [WORD_WIDTH-1:0]  o_rsp_b,
  output logic                   o_init_done
);

  // state | meaning
  // INIT  | regfile not yet usable (clearing registers when enabled)
  // RUN   | arbitrating and issuing requester commands
  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  localparam int PAD = CNTRL_WIDTH - 3*DR_WIDTH - 5;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_rr_ptr;
  logic                    r_iss_vld;
  logic                    r_iss_id;
  logic                    w_rdy0;
  logic                    w_rdy1;
  logic                    w_grant;
  logic                    w_win;
  logic [DR_WIDTH-1:0]     w_da;
  logic [DR_WIDTH-1:0]     w_aa;
  logic [DR_WIDTH-1:0]     w_ba;
  logic                    w_rw;
  logic [WORD_WIDTH-1:0]   w_data;
  logic [CNTRL_WIDTH-1:0]  w_word;
`ifdef RF_INIT_CLEAR_EN
  logic [DR_WIDTH-1:0]     r_clr_cnt;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_INIT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rdy0      = 1'b0;
    w_rdy1      = 1'b0;
    if (r_state == S_INIT) begin
`ifdef RF_INIT_CLEAR_EN
      if (&r_clr_cnt) w_state_nxt = S_RUN;
`else
      w_state_nxt = S_RUN;
`endif
    end else begin
      // On contention rr_ptr names the winner; otherwise the lone requester wins.
      if (i_req0_valid && i_req1_valid) begin
        w_rdy0 = ~r_rr_ptr;
        w_rdy1 = r_rr_ptr;
      end else begin
        w_rdy0 = i_req0_valid;
        w_rdy1 = i_req1_valid;
      end
    end
  end

  assign o_req0_ready = w_rdy0;
  assign o_req1_ready = w_rdy1;
  assign w_grant      = w_rdy0 | w_rdy1;
  assign w_win        = w_rdy1;

  assign w_da   = w_win ? i_req1_da   : i_req0_da;
  assign w_aa   = w_win ? i_req1_aa   : i_req0_aa;
  assign w_ba   = w_win ? i_req1_ba   : i_req0_ba;
  assign w_rw   = w_win ? i_req1_rw   : i_req0_rw;
  assign w_data = w_win ? i_req1_data : i_req0_data;
  assign w_word = {w_da, w_aa, w_ba, {PAD{1'b0}}, w_rw, 4'b0000};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cntrl_bus <= '0;
      o_d_bus     <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= 1'b0;
      o_rsp_a     <= '0;
      o_rsp_b     <= '0;
      o_init_done <= 1'b0;
      r_rr_ptr    <= 1'b0;
      r_iss_vld   <= 1'b0;
      r_iss_id    <= 1'b0;
`ifdef RF_INIT_CLEAR_EN
      r_clr_cnt   <= '0;
`endif
    end else begin
      r_iss_vld   <= w_grant;
      r_iss_id    <= w_win;
      o_rsp_valid <= r_iss_vld;
      // Read data is valid one edge after issue; the regfile write lands on the same edge.
      if (r_iss_vld) begin
        o_rsp_id <= r_iss_id;
        o_rsp_a  <= i_addr_bus;
        o_rsp_b  <= i_b_data;
      end
      if (r_state == S_RUN) begin
        if (w_grant) begin
          o_cntrl_bus <= w_word;
          o_d_bus     <= w_data;
          r_rr_ptr    <= ~w_win;
        end else begin
          o_cntrl_bus <= '0;
        end
      end else begin
`ifdef RF_INIT_CLEAR_EN
        o_cntrl_bus <= {r_clr_cnt, {(2*DR_WIDTH){1'b0}}, {PAD{1'b0}}, 1'b1, 4'b0000};
        o_d_bus     <= '0;
        r_clr_cnt   <= r_clr_cnt + DR_WIDTH'(1);
        if (&r_clr_cnt) o_init_done <= 1'b1;
`else
        o_cntrl_bus <= '0;
        o_init_done <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_computer_datapath_regfile_sequencer.sv
// Scoreboard bench for computer_datapath_regfile_sequencer with a behavioural regfile.
// Build with RF_INIT_CLEAR_EN defined to exercise the post-reset clear sequence.
module tb_computer_datapath_regfile_sequencer;

  typedef struct packed {
    logic [2:0]  da;
    logic [2:0]  aa;
    logic [2:0]  ba;
    logic        rw;
    logic [15:0] data;
  } cmd_t;

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    int          due;
  } exp_t;

`ifdef RF_INIT_CLEAR_EN
  localparam logic [15:0] R0V = 16'h0000;
  localparam logic [15:0] R5V = 16'h0000;
  localparam logic [15:0] R2_AFTER_RST = 16'h0000;
`else
  localparam logic [15:0] R0V = 16'h1000;
  localparam logic [15:0] R5V = 16'h1005;
  localparam logic [15:0] R2_AFTER_RST = 16'h5678;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0, v1;
  cmd_t        c0, c1;
  logic        rdy0, rdy1;
  logic [15:0] addr_bus, b_data;
  logic [19:0] cntrl;
  logic [15:0] d_bus;
  logic        rsp_valid, rsp_id, init_done;
  logic [15:0] rsp_a, rsp_b;

  logic [15:0] rf [8] = '{16'h1000, 16'h1001, 16'h1002, 16'h1003,
                          16'h1004, 16'h1005, 16'h1006, 16'h1007};
  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (cntrl[4]) rf[cntrl[19:17]] <= d_bus;
  assign addr_bus = rf[cntrl[16:14]];
  assign b_data   = rf[cntrl[13:11]];

  computer_datapath_regfile_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(v0), .o_req0_ready(rdy0),
    .i_req0_da(c0.da), .i_req0_aa(c0.aa), .i_req0_ba(c0.ba),
    .i_req0_rw(c0.rw), .i_req0_data(c0.data),
    .i_req1_valid(v1), .o_req1_ready(rdy1),
    .i_req1_da(c1.da), .i_req1_aa(c1.aa), .i_req1_ba(c1.ba),
    .i_req1_rw(c1.rw), .i_req1_data(c1.data),
    .i_addr_bus(addr_bus), .i_b_data(b_data),
    .o_cntrl_bus(cntrl), .o_d_bus(d_bus),
    .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id),
    .o_rsp_a(rsp_a), .o_rsp_b(rsp_b), .o_init_done(init_done)
  );

  function automatic cmd_t mk(input logic [2:0] da, input logic [2:0] aa,
                              input logic [2:0] ba, input logic rw, input logic [15:0] data);
    cmd_t c;
    c.da = da; c.aa = aa; c.ba = ba; c.rw = rw; c.data = data;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got id=%0d a=%h b=%h, expected no response", rsp_id, rsp_a, rsp_b);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (rsp_id !== e.id || rsp_a !== e.a || rsp_b !== e.b || cyc != e.due) begin
          n_err++;
          $display("FAIL rsp: got id=%0d a=%h b=%h cyc=%0d expected id=%0d a=%h b=%h cyc=%0d",
                   rsp_id, rsp_a, rsp_b, cyc, e.id, e.a, e.b, e.due);
        end
      end
    end
  end

  // Called at a falling edge; applies one cycle of requests and checks the grant.
  task automatic drive(input logic iv0, input cmd_t ic0, input logic iv1, input cmd_t ic1,
                       input logic e0, input logic e1, input logic [15:0] ea, input logic [15:0] eb);
    exp_t e;
    v0 = iv0; c0 = ic0; v1 = iv1; c1 = ic1;
    #1;
    chk("ready0", {31'b0, rdy0}, {31'b0, e0});
    chk("ready1", {31'b0, rdy1}, {31'b0, e1});
    if (e0 || e1) begin
      e.id = e1; e.a = ea; e.b = eb; e.due = cyc + 2;
      q.push_back(e);
    end
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_cntrl", {12'b0, cntrl}, 32'h0);
    chk("rst_d", {16'b0, d_bus}, 32'h0);
    chk("rst_ready0", {31'b0, rdy0}, 32'h0);
    chk("rst_ready1", {31'b0, rdy1}, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_id", {31'b0, rsp_id}, 32'h0);
    chk("rst_rsp_a", {16'b0, rsp_a}, 32'h0);
    chk("rst_rsp_b", {16'b0, rsp_b}, 32'h0);
    chk("rst_init_done", {31'b0, init_done}, 32'h0);
  endtask

  // Called at a falling edge with reset asserted; releases it and checks INIT.
  task automatic do_init();
    rst_n = 1'b1;
    v0 = 1'b1;
    #1;
    chk("init_ready0", {31'b0, rdy0}, 32'h0);
    chk("init_done_pre", {31'b0, init_done}, 32'h0);
    v0 = 1'b0;
`ifdef RF_INIT_CLEAR_EN
    for (int i = 0; i < 8; i++) begin
      logic [2:0] da;
      da = i[2:0];
      @(negedge clk);
      chk("clr_cntrl", {12'b0, cntrl}, {12'b0, da, 12'b0, 1'b1, 4'b0});
      chk("clr_d", {16'b0, d_bus}, 32'h0);
      chk("clr_init_done", {31'b0, init_done}, {31'b0, (i == 7)});
    end
`else
    @(negedge clk);
    chk("init_cntrl", {12'b0, cntrl}, 32'h0);
    chk("init_done", {31'b0, init_done}, 32'h1);
`endif
  endtask

  cmd_t nop;

  initial begin
    nop = '0;
    rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1; c0 = '0; c1 = '0;
    #3;
    chk_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    do_init();

    // T1: read R5 (cleared or initial contents)
    drive(1, mk(3'd0, 3'd5, 3'd0, 1'b0, 16'h0), 0, nop, 1, 0, R5V, R0V);
    chk("t1_cntrl_read", {12'b0, cntrl}, 32'h14000);

    // T2: write R3 then REQ1 reads it on both ports
    drive(1, mk(3'd3, 3'd0, 3'd0, 1'b1, 16'hBEEF), 0, nop, 1, 0, R0V, R0V);
    chk("t2_cntrl_write", {12'b0, cntrl}, 32'h60010);
    chk("t2_d_bus", {16'b0, d_bus}, 32'h0000BEEF);
    drive(0, nop, 1, mk(3'd0, 3'd3, 3'd3, 1'b0, 16'h0), 0, 1, 16'hBEEF, 16'hBEEF);
    drive(0, nop, 0, nop, 0, 0, 16'h0, 16'h0);
    chk("idle_cntrl", {12'b0, cntrl}, 32'h0);

    // T3: contention alternates starting with REQ0
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0)
        drive(1, mk(3'd0, 3'd3, 3'd0, 1'b0, 16'h0), 1, mk(3'd0, 3'd0, 3'd3, 1'b0, 16'h0),
              1, 0, 16'hBEEF, R0V);
      else
        drive(1, mk(3'd0, 3'd3, 3'd0, 1'b0, 16'h0), 1, mk(3'd0, 3'd0, 3'd3, 1'b0, 16'h0),
              0, 1, R0V, 16'hBEEF);
    end

    // T4: REQ1 alone, then REQ0 joins and wins next
    for (int k = 0; k < 3; k++)
      drive(0, nop, 1, mk(3'd0, 3'd3, 3'd3, 1'b0, 16'h0), 0, 1, 16'hBEEF, 16'hBEEF);
    drive(1, mk(3'd0, 3'd0, 3'd3, 1'b0, 16'h0), 1, mk(3'd0, 3'd3, 3'd3, 1'b0, 16'h0),
          1, 0, R0V, 16'hBEEF);
    drive(1, mk(3'd0, 3'd0, 3'd3, 1'b0, 16'h0), 1, mk(3'd0, 3'd3, 3'd3, 1'b0, 16'h0),
          0, 1, 16'hBEEF, 16'hBEEF);

    // T5: back-to-back writes, then read-after-write and read-own-destination
    drive(1, mk(3'd2, 3'd0, 3'd0, 1'b1, 16'h1234), 0, nop, 1, 0, R0V, R0V);
    drive(1, mk(3'd2, 3'd0, 3'd0, 1'b1, 16'h5678), 0, nop, 1, 0, R0V, R0V);
    drive(1, mk(3'd0, 3'd2, 3'd2, 1'b0, 16'h0), 0, nop, 1, 0, 16'h5678, 16'h5678);
    drive(1, mk(3'd4, 3'd0, 3'd0, 1'b1, 16'h0044), 0, nop, 1, 0, R0V, R0V);
    drive(1, mk(3'd4, 3'd4, 3'd0, 1'b1, 16'h0009), 0, nop, 1, 0, 16'h0044, R0V);
    drive(1, mk(3'd0, 3'd4, 3'd4, 1'b0, 16'h0), 0, nop, 1, 0, 16'h0009, 16'h0009);
    for (int k = 0; k < 4; k++) @(negedge clk);

    // T6: reset with two commands in flight
    drive(1, mk(3'd0, 3'd2, 3'd0, 1'b0, 16'h0), 0, nop, 1, 0, 16'h5678, R0V);
    v1 = 1'b1; c1 = mk(3'd0, 3'd4, 3'd0, 1'b0, 16'h0);
    #1;
    chk("t6_ready1", {31'b0, rdy1}, 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk_reset_outputs();
    @(negedge clk);
    v1 = 1'b0;
    @(negedge clk);
    do_init();
    for (int k = 0; k < 3; k++) begin
      chk("t6_no_stale_rsp", {31'b0, rsp_valid}, 32'h0);
      @(negedge clk);
    end
    drive(1, mk(3'd0, 3'd2, 3'd0, 1'b0, 16'h0), 0, nop, 1, 0, R2_AFTER_RST, R0V);

    for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
    chk("queue_drained", q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
